// File: rtl/multicycle_control.sv
// Control sequencer for a shared-memory, shared-ALU multi-cycle MIPS-subset datapath.
// Optional feature macro: MCC_ADDI_EN builds the ADDI_EXEC/ADDI_WB path for OP_ADDI.
module multicycle_control (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_ready,
    output logic       PC_en,
    output logic       IorD,
    output logic       Mem_read,
    output logic       Mem_write,
    output logic       IR_write,
    output logic       Reg_dst,
    output logic       Mem_to_reg,
    output logic       Reg_write,
    output logic       ALU_src_a,
    output logic [1:0] ALU_src_b,
    output logic [1:0] ALU_op,
    output logic [1:0] PC_source,
    output logic       Instr_done,
    output logic       Illegal_op,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LW_WB     = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BEQ       = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       pc_en_s;
    logic       iord_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_dst_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] pc_source_s;
    logic       instr_done_s;
    logic       illegal_op_s;

    // Instruction-class dispatch out of DECODE; anything unrecognised is trapped.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEM_ADDR;
            OP_RTYPE:     nxt = S_R_EXEC;
            OP_BEQ:       nxt = S_BEQ;
            OP_J:         nxt = S_JUMP;
`ifdef MCC_ADDI_EN
            OP_ADDI:      nxt = S_ADDI_EXEC;
`else
            OP_ADDI:      nxt = S_ILLEGAL;
`endif
            default:      nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // State register: reset forces FETCH immediately.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; memory states hold until Mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (Mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE:   state_d = decode_dispatch(Opcode);
            S_MEM_ADDR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEM_READ: begin
                if (Mem_ready) begin
                    state_d = S_LW_WB;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_LW_WB:     state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (Mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
`ifdef MCC_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            S_ILLEGAL:   state_d = S_ILLEGAL;
            default:     state_d = S_ILLEGAL;
        endcase
    end

    // Per-state datapath controls; anything not set in a state stays 0.
    always_comb begin
        pc_en_s      = 1'b0;
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_B;
        alu_op_s     = ALUOP_ADD;
        pc_source_s  = PCSRC_ALU;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                ir_write_s  = Mem_ready;
                pc_en_s     = Mem_ready;
            end
            S_DECODE: begin
                alu_src_b_s = SRCB_IMM_SH;
            end
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_LW_WB: begin
                mem_to_reg_s = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s  = 1'b1;
                iord_s       = 1'b1;
                instr_done_s = Mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_dst_s    = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALUOP_SUB;
                pc_source_s  = PCSRC_ALUOUT;
                pc_en_s      = Zero;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_en_s      = 1'b1;
                pc_source_s  = PCSRC_JUMP;
                instr_done_s = 1'b1;
            end
`ifdef MCC_ADDI_EN
            S_ADDI_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
            end
            S_ADDI_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
`endif
            S_ILLEGAL: begin
                illegal_op_s = 1'b1;
            end
            default: begin
                illegal_op_s = 1'b0;
            end
        endcase
    end

    // Enables and strobes are forced low while reset is held, so an abort writes nothing.
    assign PC_en      = pc_en_s      & Reset_n;
    assign IorD       = iord_s;
    assign Mem_read   = mem_read_s   & Reset_n;
    assign Mem_write  = mem_write_s  & Reset_n;
    assign IR_write   = ir_write_s   & Reset_n;
    assign Reg_dst    = reg_dst_s;
    assign Mem_to_reg = mem_to_reg_s;
    assign Reg_write  = reg_write_s  & Reset_n;
    assign ALU_src_a  = alu_src_a_s;
    assign ALU_src_b  = alu_src_b_s;
    assign ALU_op     = alu_op_s;
    assign PC_source  = pc_source_s;
    assign Instr_done = instr_done_s & Reset_n;
    assign Illegal_op = illegal_op_s & Reset_n;
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, scoreboard-based bench for multicycle_control; honours MCC_ADDI_EN.
module tb_multicycle_control;

    logic       Clk;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       Mem_ready;
    logic       PC_en, IorD, Mem_read, Mem_write, IR_write;
    logic       Reg_dst, Mem_to_reg, Reg_write, ALU_src_a;
    logic [1:0] ALU_src_b, ALU_op, PC_source;
    logic       Instr_done, Illegal_op;
    logic [3:0] State;

    int n_checks = 0;
    int n_fail   = 0;
    logic [20:0] sb_q[$];
    logic [20:0] dut_vec;

    multicycle_control dut (
        .Clk(Clk), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .Mem_ready(Mem_ready),
        .PC_en(PC_en), .IorD(IorD), .Mem_read(Mem_read), .Mem_write(Mem_write),
        .IR_write(IR_write), .Reg_dst(Reg_dst), .Mem_to_reg(Mem_to_reg), .Reg_write(Reg_write),
        .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_op(ALU_op), .PC_source(PC_source),
        .Instr_done(Instr_done), .Illegal_op(Illegal_op), .State(State)
    );

    assign dut_vec = {State, PC_en, IorD, Mem_read, Mem_write, IR_write, Reg_dst, Mem_to_reg,
                      Reg_write, ALU_src_a, ALU_src_b, ALU_op, PC_source, Instr_done, Illegal_op};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [3:0] st, input logic pcen, input logic iord,
                            input logic mrd, input logic mwr, input logic irw,
                            input logic rdst, input logic m2r, input logic rw,
                            input logic sa, input logic [1:0] sb, input logic [1:0] aop,
                            input logic [1:0] pcs, input logic done, input logic ill);
        sb_q.push_back({st, pcen, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, pcs, done, ill});
    endtask

    task automatic e_reset();  push_exp(4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_fetch(input logic mr); push_exp(4'd0, mr,1'b0,1'b1,1'b0,mr, 1'b0,1'b0,1'b0, 1'b0,2'b01,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_decode(); push_exp(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b11,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_maddr();  push_exp(4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b10,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_mread();  push_exp(4'd3, 1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_lwwb();   push_exp(4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0,2'b00,2'b00,2'b00, 1'b1,1'b0); endtask
    task automatic e_mwrite(input logic mr); push_exp(4'd5, 1'b0,1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b00, mr,1'b0); endtask
    task automatic e_rexec();  push_exp(4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b10,2'b00, 1'b0,1'b0); endtask
    task automatic e_rwb();    push_exp(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 1'b0,2'b00,2'b00,2'b00, 1'b1,1'b0); endtask
    task automatic e_beq(input logic z); push_exp(4'd8, z,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b00,2'b01,2'b01, 1'b1,1'b0); endtask
    task automatic e_jump();   push_exp(4'd9, 1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b10, 1'b1,1'b0); endtask
    task automatic e_aexec();  push_exp(4'd10, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,2'b10,2'b00,2'b00, 1'b0,1'b0); endtask
    task automatic e_awb();    push_exp(4'd11, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,2'b00,2'b00,2'b00, 1'b1,1'b0); endtask
    task automatic e_illegal(); push_exp(4'd12, 1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,2'b00,2'b00,2'b00, 1'b0,1'b1); endtask

    task automatic check(input string tag);
        logic [20:0] exp_v;
        n_checks++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed vec=%b", tag, dut_vec);
        end
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            n_checks++;
            assert (dut_vec === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed state=%0d vec=%b expected state=%0d vec=%b",
                       tag, dut_vec[20:17], dut_vec, exp_v[20:17], exp_v);
            end
        end
    endtask

    // Drive inputs for one cycle, compare at the falling edge, leave 1 time unit past the next rise.
    task automatic cyc(input logic mr, input logic z, input string tag);
        Mem_ready = mr;
        Zero      = z;
        @(negedge Clk);
        check(tag);
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        Reset_n = 1'b0;
        #1;
        e_reset();
        check({tag, "_async"});
        @(posedge Clk);
        #1;
        e_reset();
        check({tag, "_held"});
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n   = 1'b0;
        Opcode    = 6'h00;
        Zero      = 1'b0;
        Mem_ready = 1'b1;
        #2;
        e_reset(); check("rst_init");
        @(posedge Clk); #1;
        e_reset(); check("rst_hold");
        Reset_n = 1'b1;

        // R-type straight out of reset: Instr_done on the 4th cycle
        Opcode = 6'h00;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "rt_fetch");
        e_decode();    cyc(1'b1, 1'b0, "rt_decode");
        e_rexec();     cyc(1'b1, 1'b0, "rt_exec");
        e_rwb();       cyc(1'b1, 1'b0, "rt_wb");

        // reset pulsed mid-FETCH with Mem_ready high
        Mem_ready = 1'b1;
        pulse_reset("rst_midfetch");

        // R-type again; Mem_ready ignored outside memory states, Opcode ignored after DECODE
        Opcode = 6'h00;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "rt2_fetch");
        e_decode();    cyc(1'b0, 1'b1, "rt2_decode");
        Opcode = 6'h23;
        e_rexec();     cyc(1'b0, 1'b1, "rt2_exec");
        e_rwb();       cyc(1'b0, 1'b0, "rt2_wb");

        // LW with two wait cycles in MEM_READ: 7 cycles
        Opcode = 6'h23;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "lw_fetch");
        e_decode();    cyc(1'b1, 1'b0, "lw_decode");
        e_maddr();     cyc(1'b1, 1'b0, "lw_maddr");
        e_mread();     cyc(1'b0, 1'b0, "lw_mread_w1");
        e_mread();     cyc(1'b0, 1'b0, "lw_mread_w2");
        e_mread();     cyc(1'b1, 1'b0, "lw_mread_go");
        e_lwwb();      cyc(1'b1, 1'b0, "lw_wb");

        // SW with one FETCH wait cycle
        Opcode = 6'h2B;
        e_fetch(1'b0); cyc(1'b0, 1'b0, "sw_fetch_wait");
        e_fetch(1'b1); cyc(1'b1, 1'b0, "sw_fetch");
        e_decode();    cyc(1'b1, 1'b0, "sw_decode");
        e_maddr();     cyc(1'b1, 1'b0, "sw_maddr");
        e_mwrite(1'b1); cyc(1'b1, 1'b0, "sw_mwrite");

        // BEQ taken and not taken
        Opcode = 6'h04;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "beq1_fetch");
        e_decode();    cyc(1'b1, 1'b0, "beq1_decode");
        e_beq(1'b1);   cyc(1'b1, 1'b1, "beq1_taken");
        e_fetch(1'b1); cyc(1'b1, 1'b1, "beq0_fetch");
        e_decode();    cyc(1'b1, 1'b1, "beq0_decode");
        e_beq(1'b0);   cyc(1'b1, 1'b0, "beq0_not_taken");

        // J
        Opcode = 6'h02;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "j_fetch");
        e_decode();    cyc(1'b1, 1'b0, "j_decode");
        e_jump();      cyc(1'b1, 1'b0, "j_jump");

        // SW with one MEM_WRITE wait cycle
        Opcode = 6'h2B;
        e_fetch(1'b1);  cyc(1'b1, 1'b0, "sw2_fetch");
        e_decode();     cyc(1'b1, 1'b0, "sw2_decode");
        e_maddr();      cyc(1'b1, 1'b0, "sw2_maddr");
        e_mwrite(1'b0); cyc(1'b0, 1'b0, "sw2_mwrite_wait");
        e_mwrite(1'b1); cyc(1'b1, 1'b0, "sw2_mwrite");

        // ADDI: executes with the macro, trapped without it
        Opcode = 6'h08;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "addi_fetch");
        e_decode();    cyc(1'b1, 1'b0, "addi_decode");
`ifdef MCC_ADDI_EN
        e_aexec();     cyc(1'b1, 1'b0, "addi_exec");
        e_awb();       cyc(1'b1, 1'b0, "addi_wb");
`else
        e_illegal();   cyc(1'b1, 1'b0, "addi_illegal");
        pulse_reset("rst_after_addi");
`endif

        // reset during MEM_READ aborts the load
        Opcode = 6'h23;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "lwab_fetch");
        e_decode();    cyc(1'b1, 1'b0, "lwab_decode");
        e_maddr();     cyc(1'b1, 1'b0, "lwab_maddr");
        e_mread();     cyc(1'b0, 1'b0, "lwab_mread");
        Mem_ready = 1'b1;
        pulse_reset("rst_midread");

        // unsupported opcode: absorbing ILLEGAL for 20 cycles of arbitrary input
        Opcode = 6'h3F;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "ill_fetch");
        e_decode();    cyc(1'b1, 1'b0, "ill_decode");
        for (int i = 0; i < 20; i++) begin
            Opcode = 6'($urandom_range(63, 0));
            e_illegal();
            cyc(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "ill_hold");
        end
        pulse_reset("rst_clear_illegal");

        // recovery after clearing ILLEGAL
        Opcode = 6'h00;
        e_fetch(1'b1); cyc(1'b1, 1'b0, "rt3_fetch");
        e_decode();    cyc(1'b1, 1'b0, "rt3_decode");
        e_rexec();     cyc(1'b1, 1'b0, "rt3_exec");
        e_rwb();       cyc(1'b1, 1'b0, "rt3_wb");

        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control sequencer that drives a shared multi-cycle MIPS-subset datapath: one memory port for instructions and data, one ALU for PC increment, branch target and execution. It is a Moore/Mealy FSM that walks each instruction through FETCH, DECODE and per-class execute/memory/write-back states. It throttles on a memory-ready handshake and flags unsupported opcodes. It sits beside the register file, ALU and memory in the top-level processor.

## Interface
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-if-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode (used only with MCC_ADDI_EN)
- Clk  in  1  clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- Mem_ready  in  1  memory completes the current read/write this cycle
- PC_en  out  1  PC load enable (PCWrite | PCWriteCond&Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_read, Mem_write  out  1 each  memory strobes
- IR_write  out  1  instruction register load
- Reg_dst  out  1  write register: 0 = rt, 1 = rd
- Mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
- Reg_write  out  1  register file write enable
- ALU_src_a  out  1  0 = PC, 1 = A
- ALU_src_b  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- ALU_op  out  2  00 add, 01 sub, 10 funct-decoded
- PC_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- Instr_done  out  1  one-cycle pulse in an instruction's final state
- Illegal_op  out  1  sticky unsupported-opcode flag
- State  out  4  current state, debug

## Operation
- States, with 4-bit encoding in brackets:
  - FETCH[0]: Mem_read, IorD=0, src_a=0, src_b=01, ALU_op=00. IR_write and PC_en are asserted only when Mem_ready=1. Stays in FETCH while Mem_ready=0; otherwise goes to DECODE.
  - DECODE[1]: src_a=0, src_b=11, ALU_op=00. Next state by Opcode: LW/SW → MEM_ADDR, RTYPE → R_EXEC, BEQ → BEQ, J → JUMP, ADDI → ADDI_EXEC (macro), anything else → ILLEGAL.
  - MEM_ADDR[2]: src_a=1, src_b=10, ALU_op=00. LW → MEM_READ, SW → MEM_WRITE.
  - MEM_READ[3]: Mem_read, IorD=1. Holds until Mem_ready, then → LW_WB.
  - LW_WB[4]: Reg_dst=0, Mem_to_reg=1, Reg_write, Instr_done → FETCH.
  - MEM_WRITE[5]: Mem_write, IorD=1. Holds until Mem_ready; in the Mem_ready cycle asserts Instr_done → FETCH.
  - R_EXEC[6]: src_a=1, src_b=00, ALU_op=10 → R_WB.
  - R_WB[7]: Reg_dst=1, Mem_to_reg=0, Reg_write, Instr_done → FETCH.
  - BEQ[8]: src_a=1, src_b=00, ALU_op=01, PC_source=01, PC_en=Zero, Instr_done → FETCH.
  - JUMP[9]: PC_en=1, PC_source=10, Instr_done → FETCH.
  - ADDI_EXEC[10]: src_a=1, src_b=10, ALU_op=00 → ADDI_WB.
  - ADDI_WB[11]: Reg_dst=0, Mem_to_reg=0, Reg_write, Instr_done → FETCH.
  - ILLEGAL[12]: Illegal_op=1, all enables/strobes 0. Absorbing; left only by reset.
- Unused encodings 13–15 → ILLEGAL on the next edge.
- Any output not listed for a state is 0.

## Timing
- Reset_n low: State=FETCH immediately (asynchronous). All enables, strobes, Instr_done and Illegal_op are 0, gated by Reset_n. Mux selects take their FETCH values.
- The first fetch begins at the first rising edge after Reset_n deasserts.
- Reset asserted mid-instruction aborts it at once, with no further writes.
- Outputs are combinational from State, gated by Mem_ready/Zero. Transitions are registered, so each state lasts at least one cycle.
- Cycles per instruction with Mem_ready held at 1: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each Mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- Mem_ready is sampled only in the memory states and ignored elsewhere.
- Opcode is sampled only in DECODE and MEM_ADDR.

## Configuration
- MCC_ADDI_EN defined: OP_ADDI is decoded to ADDI_EXEC/ADDI_WB.
- MCC_ADDI_EN undefined: states 10/11 are not built, their encodings behave as unused, and OP_ADDI goes to ILLEGAL.

## Test plan
- Reset_n pulsed low mid-FETCH with Mem_ready=1: State=0 and all enables 0 during reset. Instr_done is first seen 4 cycles after release for Opcode=6'h00.
- Opcode=6'h23 with Mem_ready low for 2 cycles in MEM_READ: LW takes 7 cycles. Reg_write=1 and Mem_to_reg=1 exactly in LW_WB.
- Opcode=6'h04: Zero=1 gives PC_en=1 with PC_source=01 in BEQ; Zero=0 gives PC_en=0. Both take 3 cycles.
- Opcode=6'h2B, Mem_ready=1: Mem_write=1, IorD=1 for one cycle. Reg_write stays 0 throughout, and Instr_done pulses in MEM_WRITE.
- Opcode=6'h3F: State goes to 12 after DECODE and Illegal_op=1 holds through 20 cycles of arbitrary input. Reset_n low clears it.
- Opcode=6'h08: with MCC_ADDI_EN, 4 cycles with Reg_dst=0, src_b=10; without it, Illegal_op=1.
